// File: rtl/lsu_mem_master.sv
// lsu_mem_master: load/store initiator for the data memory (WE/RE/A/WD/RD master).
// Accepts 1..MAX_BURST byte load/store bursts over a valid/ready handshake and
// issues one memory access per cycle, absorbing the memory's 1-cycle read latency.
// Optional feature macro: LSU_WPROT_EN (store-beat write protection at/above PROT_BASE,
// with a sticky err flag). Without it every store beat writes and err is 0.
//
// Handshake: a request transfers on a rising Clk edge where req_valid && req_ready;
// req_ready is high only in IDLE. The response channel has no ready: each rsp_valid
// pulse is one beat that the consumer must take in that cycle.
module lsu_mem_master #(
    parameter int              ADDR_W    = 8,
    parameter int              DATA_W    = 8,
    parameter int              MAX_BURST = 4,
    parameter logic [ADDR_W-1:0] PROT_BASE = 8'hF0,
    localparam int             LEN_W     = $clog2(MAX_BURST)
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [LEN_W-1:0]              req_len,
    input  logic [DATA_W*MAX_BURST-1:0]   req_wdata,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_last,
    output logic                          busy,
    output logic                          err,
    output logic                          mem_we,
    output logic                          mem_re,
    output logic [ADDR_W-1:0]             mem_a,
    output logic [DATA_W-1:0]             mem_wd,
    input  logic [DATA_W-1:0]             mem_rd,
    output logic [2:0]                    dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_ACK   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]                  state;
    logic [ADDR_W-1:0]           base_q;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            beat_q;
    logic [DATA_W*MAX_BURST-1:0] wdata_q;
    logic                        pend_v;     // a read was issued last cycle; mem_rd is valid now
    logic                        pend_last;  // that read was the final beat of the burst
    logic [ADDR_W-1:0]           addr_cur;
    logic                        wprot_en;
    logic                        prot_hit;

`ifdef LSU_WPROT_EN
    assign wprot_en = 1'b1;
`else
    assign wprot_en = 1'b0;
`endif

    assign addr_cur  = base_q + ADDR_W'(beat_q);
    assign prot_hit  = wprot_en && (state == S_WRITE) && (addr_cur >= PROT_BASE);
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // Memory strobes decoded purely from registered state, base and beat counter.
    always_comb begin
        mem_we = 1'b0;
        mem_re = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (state == S_WRITE) begin
            mem_a  = addr_cur;
            mem_wd = wdata_q[beat_q*DATA_W +: DATA_W];
            mem_we = !prot_hit;
        end else if (state == S_READ) begin
            mem_a  = addr_cur;
            mem_re = 1'b1;
        end
    end

    // Request sequencing FSM plus the registered response pipeline.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            wdata_q   <= '0;
            pend_v    <= 1'b0;
            pend_last <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            pend_v    <= 1'b0;
            pend_last <= 1'b0;
            // A read issued last cycle has its byte on mem_rd now.
            if (pend_v) begin
                rsp_valid <= 1'b1;
                rsp_data  <= mem_rd;
                rsp_last  <= pend_last;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        base_q  <= req_addr;
                        len_q   <= req_len;
                        wdata_q <= req_wdata;
                        beat_q  <= '0;
                        state   <= req_we ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    beat_q <= beat_q + 1'b1;
                    if (beat_q == len_q) begin
                        state     <= S_ACK;
                        rsp_valid <= 1'b1;
                        rsp_last  <= 1'b1;
                        rsp_data  <= '0;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                S_READ: begin
                    pend_v    <= 1'b1;
                    pend_last <= (beat_q == len_q);
                    beat_q    <= beat_q + 1'b1;
                    if (beat_q == len_q) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave once the final load byte is on the response outputs.
                    if (rsp_last) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LSU_WPROT_EN
    logic err_q;
    // Sticky flag: set by any store beat that was suppressed by protection.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            err_q <= 1'b0;
        end else if (prot_hit) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: randomized bench for lsu_mem_master with a transaction-level
// reference model (reference memory image plus cycle timeline derived from burst length).
module tb_lsu_mem_master;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr;
    logic [1:0]  req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_last, busy, err;
    logic [7:0]  rsp_data;
    logic        mem_we, mem_re;
    logic [7:0]  mem_a, mem_wd;
    logic [7:0]  mem_rd;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem     [256];  // memory slave attached to the DUT
    logic [7:0] ref_mem [256];  // expected memory image
    logic       ref_err;
    logic [7:0] exp_q[$];       // expected response bytes, in order

    lsu_mem_master dut (
        .Clk(Clk), .Rst(Rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .busy(busy), .err(err),
        .mem_we(mem_we), .mem_re(mem_re), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .dbg_state(dbg_state)
    );

    // Clock / synchronous memory slave with 1-cycle read latency.
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mem_we) mem[mem_a] <= mem_wd;
        if (mem_re) mem_rd <= mem[mem_a];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_prot(input logic [7:0] a);
`ifdef LSU_WPROT_EN
        return a >= 8'hF0;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one request from an idle negedge and check every cycle until idle again.
    task automatic run_req(input bit we, input logic [7:0] addr, input logic [1:0] len,
                           input logic [31:0] wd, input bit hold_valid);
        int nb = int'(len) + 1;
        int last_cycle = we ? nb + 1 : nb + 2;
        logic [7:0] a;
        check_eq("ready_before", req_ready, 1);
        check_eq("busy_before", busy, 0);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = wd;
        if (we) begin
            for (int k = 0; k < nb; k++) begin
                a = addr + 8'(k);
                if (is_prot(a)) ref_err = 1'b1;
                else ref_mem[a] = wd[8*k +: 8];
            end
            exp_q.push_back(8'h00);
        end else begin
            for (int k = 0; k < nb; k++) begin
                a = addr + 8'(k);
                exp_q.push_back(ref_mem[a]);
            end
        end
        for (int c = 1; c <= last_cycle + 1; c++) begin
            bit issue, exp_rsp, exp_last;
            logic [7:0] eb;
            @(negedge Clk);
            if (c == 1 && !hold_valid) req_valid = 1'b0;
            if (hold_valid) begin
                req_addr = 8'($urandom); req_we = 1'($urandom);
                if (c == last_cycle + 1) req_valid = 1'b0;
            end
            if (c <= last_cycle) begin
                check_eq("ready_busy", req_ready, 0);
                check_eq("busy", busy, 1);
            end else begin
                check_eq("ready_done", req_ready, 1);
                check_eq("busy_done", busy, 0);
            end
            issue = (c <= nb);
            a = addr + 8'(c - 1);
            check_eq("mem_we", mem_we, we && issue && !is_prot(a));
            check_eq("mem_re", mem_re, !we && issue);
            check_eq("we_re_excl", mem_we && mem_re, 0);
            if (issue) check_eq("mem_a", mem_a, a);
            if (issue && we) check_eq("mem_wd", mem_wd, wd[8*(c-1) +: 8]);
            exp_rsp  = we ? (c == nb + 1) : (c >= 3 && c <= nb + 2);
            exp_last = we ? (c == nb + 1) : (c == nb + 2);
            check_eq("rsp_valid", rsp_valid, exp_rsp);
            check_eq("rsp_last", rsp_last, exp_last);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 1, 0);
                end else begin
                    eb = exp_q.pop_front();
                    check_eq("rsp_data", rsp_data, eb);
                end
            end
        end
        check_eq("exp_q_empty", exp_q.size(), 0);
        exp_q.delete();
        check_eq("err", err, ref_err);
        if (we) begin
            for (int k = 0; k < nb; k++) begin
                a = addr + 8'(k);
                check_eq("mem_image", mem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, req_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_mem_we"}, mem_we, 0);
        check_eq({tag, "_mem_re"}, mem_re, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_last"}, rsp_last, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_mem_a"}, mem_a, 0);
        check_eq({tag, "_mem_wd"}, mem_wd, 0);
    endtask

    initial begin
        logic [31:0] wd;
        logic [7:0]  old_f0;
        Rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        req_wdata = '0; mem_rd = '0; ref_err = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        // Directed: single load, wrapping burst store, burst load back, busy rejection.
        mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
        run_req(1'b0, 8'h10, 2'd0, 32'h0, 1'b0);
        run_req(1'b1, 8'hFE, 2'd3, 32'h44332211, 1'b0);
        run_req(1'b0, 8'hFE, 2'd3, 32'h0, 1'b0);
        run_req(1'b0, 8'hFE, 2'd3, 32'h0, 1'b1);
        run_req(1'b1, 8'h20, 2'd2, 32'h00CCBBAA, 1'b1);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            run_req(1'($urandom), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                    $urandom, ($urandom_range(0, 3) == 0));
        end

        // Reset in cycle 2 of a 4-beat store: only beat 0 lands.
        wd = $urandom;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h40; req_len = 2'd3; req_wdata = wd;
        @(negedge Clk);
        req_valid = 1'b0;
        check_eq("midrst_beat0_we", mem_we, 1);
        check_eq("midrst_beat0_a", mem_a, 8'h40);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        ref_mem[8'h40] = wd[7:0];
        ref_err = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            check_eq("midrst_mem", mem[8'h40 + 8'(k)], ref_mem[8'h40 + 8'(k)]);
        end
        check_eq("midrst_no_ack", rsp_valid, 0);
        run_req(1'b0, 8'h40, 2'd3, 32'h0, 1'b0);

`ifdef LSU_WPROT_EN
        // Two-beat store straddling the protection boundary.
        old_f0 = ref_mem[8'hF0];
        run_req(1'b1, 8'hEF, 2'd1, 32'h0000BBAA, 1'b0);
        check_eq("prot_ef", mem[8'hEF], 8'hAA);
        check_eq("prot_f0", mem[8'hF0], old_f0);
        check_eq("prot_err", err, 1);
        run_req(1'b0, 8'hEF, 2'd1, 32'h0, 1'b0);
        check_eq("prot_err_sticky", err, 1);
`else
        old_f0 = 8'h00;
        run_req(1'b1, 8'hEF, 2'd1, 32'h0000BBAA, 1'b0);
        check_eq("noprot_ef", mem[8'hEF], 8'hAA);
        check_eq("noprot_f0", mem[8'hF0], 8'hBB);
        check_eq("noprot_err", err, old_f0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator for the 8-bit pipelined processor's data memory: the master end of the WE/RE/A/WD/RD interface.
- Accepts single or burst (1–4 byte) load/store requests from the MEM stage over a valid/ready handshake.
- Sequences one memory access per cycle and accounts for the memory's 1-cycle synchronous read latency.
- Returns load bytes, or a store acknowledge, on a response channel.

Parameters:
- ADDR_W, 8, address width; the address counter wraps modulo 2^ADDR_W.
- DATA_W, 8, byte width.
- MAX_BURST, 4, maximum beats per request; req_len width is log2(MAX_BURST).
- PROT_BASE, 8'hF0, lowest write-protected address; used only with LSU_WPROT_EN.

Ports:
- Clk  in  1  clock; all flops on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  base address.
- req_len  in  2  beats minus 1 (0 → 1 beat, 3 → 4 beats).
- req_wdata  in  DATA_W*MAX_BURST  store bytes; byte k in bits [8k+7:8k].
- rsp_valid  out  1  response beat valid, 1-cycle pulse per beat.
- rsp_data  out  DATA_W  load byte; 0 for store acknowledge.
- rsp_last  out  1  final response beat of the request.
- busy  out  1  request in flight (not IDLE).
- err  out  1  sticky protection violation (LSU_WPROT_EN only).
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_a  out  ADDR_W  memory address.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data; valid the cycle after mem_re is sampled.

Behaviour:
- Reset (async):
  - state = IDLE.
  - req_ready = 1.
  - busy, rsp_valid, rsp_last, mem_we, mem_re, err = 0.
  - rsp_data, mem_a, mem_wd, and the address, beat, and pending registers = 0.
- Accept: req_valid & req_ready at a rising edge (E0).
  - Latch req_we, req_addr, req_len, req_wdata.
  - beat = 0; go to WRITE or READ.
  - No request is accepted outside IDLE.
- Memory outputs are decoded only from registers, never combinationally from req_*.
  - mem_a = base + beat, mod 2^ADDR_W (0xFF + 1 → 0x00).
- WRITE state:
  - Each cycle: mem_we = 1, mem_wd = latched byte[beat], mem_re = 0.
  - beat increments; after beat == len, go to ACK.
- ACK state (one cycle):
  - rsp_valid = 1, rsp_last = 1, rsp_data = 0.
  - Next state is IDLE.
  - A store of L beats occupies cycles 1..L after E0; the ack appears in cycle L+1.
- READ state:
  - Each cycle: mem_re = 1, mem_we = 0, and a pending bit is shifted in.
  - The cycle after a beat is issued, mem_rd holds that byte.
  - At the next edge: rsp_data <= mem_rd, rsp_valid <= 1, rsp_last <= (that beat == len).
  - After the last issue, go to DRAIN.
- Load timing:
  - Beat k is issued in cycle k+1 after E0 and responded in cycle k+3.
  - Back-to-back beats give one response per cycle.
- DRAIN state:
  - mem_re = 0; wait until the last response has been registered.
  - Return to IDLE in the same cycle rsp_last is high; req_ready is high the following cycle.
- General rules:
  - busy = !IDLE.
  - rsp_valid is never back-pressured; the consumer must take every beat.
  - mem_we and mem_re are never high in the same cycle.
- Reset mid-operation: outputs return to reset values immediately and the remaining beats are discarded.
- req_len = 0 is a legal single beat.

Optional Feature:
- Macro: LSU_WPROT_EN.
- When defined:
  - Any store beat with address >= PROT_BASE drives mem_we = 0 for that beat; the beat slot, address, and timing are unchanged.
  - err is set at that edge and stays set until Rst.
  - Other beats of the burst still write; the ack is still issued.
- When not defined:
  - err is tied to 0.
  - All store beats write.

Test Plan:
- Reset check: assert Rst mid-cycle → req_ready = 1; busy, mem_we, mem_re, rsp_valid, err, mem_a all = 0, asynchronously.
- Single load: mem[0x10] = 0xA5; load addr 0x10, len 0 → mem_re with mem_a = 0x10 in cycle 1; rsp_valid = 1, rsp_data = 0xA5, rsp_last = 1 in cycle 3; req_ready = 1 in cycle 4.
- Burst store with wrap: store addr 0xFE, len 3, wdata 0x44332211 → mem_a = FE, FF, 00, 01 in cycles 1–4; mem[FE] = 11, mem[FF] = 22, mem[00] = 33, mem[01] = 44; ack (rsp_valid, rsp_last, rsp_data = 0) in cycle 5.
- Burst load back: load 0xFE, len 3 → rsp_data 11, 22, 33, 44 in cycles 3–6, rsp_last only in cycle 6; mem_re never high when mem_we is high.
- Busy rejection and mid-operation reset:
  - req_valid held high during a burst → req_ready = 0 and no second accept until the first request's rsp_last.
  - Rst asserted in cycle 2 of a 4-beat store → only beat 0 is written, no ack, returns to IDLE.
- Protection (LSU_WPROT_EN defined, PROT_BASE = 0xF0): store 0xEF, len 1, bytes AA, BB → mem[EF] = AA, mem[F0] unchanged; err = 1 stays set; ack still issued.
